// File: rtl/stream_pattern_gen_pkg.sv
// Shared types and constants for the stream pattern generator and its checkers.
// lfsr32_next is the single definition of the PRBS-32 step used by RTL and bench.
package stream_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic MODE_CNT  = 1'b0;
    localparam logic MODE_PRBS = 1'b1;

    // Taps for x^32 + x^22 + x^2 + x + 1 -> bits 31, 21, 1, 0
    localparam logic [31:0] PRBS32_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr32_next(input logic [31:0] i_value);
        return {i_value[30:0], ^(i_value & PRBS32_TAPS)};
    endfunction

endpackage

// File: rtl/stream_pattern_gen_if.sv
// Valid/ready stream bundle driven by the pattern generator.
// The master drives valid/data/last; the slave answers with ready.
interface stream_pattern_gen_if #(
    parameter int P_DATA_W = 32
) ();
    logic                m_valid;
    logic                m_ready;
    logic [P_DATA_W-1:0] m_data;
    logic                m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/stream_pattern_gen_lfsr.sv
// Fibonacci PRBS-32 register; steps only when i_adv is high.
// Seeded from P_SEED on reset and never reseeded otherwise.
import stream_pattern_pkg::*;

module prbs32_lfsr #(
    parameter logic [31:0] P_SEED = 32'h0000_0001
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_adv,
    output logic [31:0] o_value
);
    logic [31:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= P_SEED;
        end else if (i_adv) begin
            r_lfsr <= lfsr32_next(r_lfsr);
        end
    end

    assign o_value = r_lfsr;
endmodule

// File: rtl/stream_pattern_gen.sv
// Frame-based valid/ready traffic source: counter or PRBS-32 payload, m_last on the final beat.
// state | meaning
// IDLE  | waiting for start with a nonzero frame length
// SEND  | presenting beats; advances on each accepted beat
// FIN   | one cycle: done pulse, frame counter already bumped
import stream_pattern_pkg::*;

module stream_pattern_gen #(
    parameter int          P_DATA_W = 32,
    parameter int          P_LEN_W  = 16,
    parameter logic [31:0] P_SEED   = 32'h0000_0001
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic [P_LEN_W-1:0] i_frame_len,
    output logic               o_busy,
    output logic               o_done,
    output logic [P_LEN_W-1:0] o_frame_cnt,
    stream_pattern_gen_if.master m_if
);
    state_t              r_state;
    logic [P_LEN_W-1:0]  r_len;
    logic [P_LEN_W-1:0]  r_beat_idx;
    logic [P_LEN_W-1:0]  r_frame_cnt;
    logic                r_mode;
    logic                r_busy;
    logic                r_done;
    logic                r_valid;
    logic                r_last;
    logic [P_DATA_W-1:0] r_data;

    logic                w_accept;
    logic [P_LEN_W-1:0]  w_idx_next;
    logic [31:0]         w_lfsr;
    logic [31:0]         w_lfsr_next;

    assign w_accept    = r_valid && m_if.m_ready;
    assign w_idx_next  = r_beat_idx + 1'b1;
    assign w_lfsr_next = lfsr32_next(w_lfsr);

    // The LFSR steps in lockstep with accepted PRBS beats, so its next value is the next payload.
    prbs32_lfsr #(.P_SEED(P_SEED)) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_adv  (r_state == SEND && w_accept && r_mode == MODE_PRBS),
        .o_value(w_lfsr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_beat_idx  <= '0;
            r_frame_cnt <= '0;
            r_mode      <= MODE_CNT;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start && i_frame_len != '0) begin
                        r_state    <= SEND;
                        r_len      <= i_frame_len;
                        r_mode     <= i_mode;
                        r_beat_idx <= '0;
                        r_busy     <= 1'b1;
                        r_valid    <= 1'b1;
                        r_last     <= (i_frame_len == P_LEN_W'(1));
                        r_data     <= (i_mode == MODE_PRBS) ? w_lfsr[P_DATA_W-1:0] : '0;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (r_last) begin
                            r_state     <= FIN;
                            r_valid     <= 1'b0;
                            r_last      <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end else begin
                            r_beat_idx <= w_idx_next;
                            r_last     <= (w_idx_next == r_len - 1'b1);
                            r_data     <= (r_mode == MODE_PRBS) ? w_lfsr_next[P_DATA_W-1:0]
                                                                : P_DATA_W'(w_idx_next);
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_frame_cnt  = r_frame_cnt;
    assign m_if.m_valid = r_valid;
    assign m_if.m_last  = r_last;
    assign m_if.m_data  = r_data;
endmodule
